cb_mode_sequencer: RTL

//  Sequences a safe-CPU-wrapper mode change: on a start request it drains all harts to quiescence,

---
 rtl/cb_mode_sequencer_pkg.sv | 33 +++
 rtl/cb_mode_sequencer_if.sv | 43 ++++
 rtl/cb_mode_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cb_mode_sequencer_pkg.sv
// Shared types for the safe-CPU-wrapper mode-change sequencer: FSM states,
// interrupt status codes and the latched configuration record.
package cb_mode_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_APPLY   = 3'd2,
        ST_START   = 3'd3,
        ST_RUN     = 3'd4,
        ST_DONE    = 3'd5,
        ST_TIMEOUT = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_DONE    = 2'b01,
        STAT_TIMEOUT = 2'b10,
        STAT_ABORT   = 2'b11
    } seq_status_e;

    typedef struct packed {
        logic        safe_mode;
        logic [1:0]  safe_config;
        logic [2:0]  master_core;
        logic [31:0] boot_addr;
    } cfg_shadow_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cb_mode_sequencer_if.sv
// Control/status bundle between the CSR block, the sequencer and the safe CPU wrapper.
// master = CSR/hart side driving requests, slave = the sequencer.
interface cb_mode_sequencer_if #(
    parameter int NHARTS = 3
);
    logic              start_req_i;
    logic              abort_i;
    logic              irq_clr_i;
    logic              cfg_safe_mode_i;
    logic [1:0]        cfg_safe_config_i;
    logic [2:0]        cfg_master_core_i;
    logic [31:0]       cfg_boot_addr_i;
    logic [NHARTS-1:0] debug_mode_i;
    logic [NHARTS-1:0] sleep_i;
    logic              EndSw_i;

    logic              safe_mode_o;
    logic [1:0]        safe_configuration_o;
    logic [2:0]        master_core_o;
    logic [31:0]       boot_addr_o;
    logic              Start_o;
    logic [NHARTS-1:0] debug_req_o;
    logic              busy_o;
    logic [1:0]        status_o;
    logic              interrupt_o;

    modport master (
        output start_req_i, abort_i, irq_clr_i,
        output cfg_safe_mode_i, cfg_safe_config_i, cfg_master_core_i, cfg_boot_addr_i,
        output debug_mode_i, sleep_i, EndSw_i,
        input  safe_mode_o, safe_configuration_o, master_core_o, boot_addr_o,
        input  Start_o, debug_req_o, busy_o, status_o, interrupt_o
    );

    modport slave (
        input  start_req_i, abort_i, irq_clr_i,
        input  cfg_safe_mode_i, cfg_safe_config_i, cfg_master_core_i, cfg_boot_addr_i,
        input  debug_mode_i, sleep_i, EndSw_i,
        output safe_mode_o, safe_configuration_o, master_core_o, boot_addr_o,
        output Start_o, debug_req_o, busy_o, status_o, interrupt_o
    );

endinterface

// File: rtl/cb_mode_sequencer.sv
// Safe-CPU-wrapper mode-change sequencer: drain harts, apply latched config, pulse Start, await EndSw.
// Optional hart halting during drain is enabled by defining CB_SEQ_DEBUG_HALT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start_req_i; config captured on the request
// ST_DRAIN   | waiting for all harts quiescent, bounded by TIMEOUT_CYC
// ST_APPLY   | one cycle with the new config on the outputs
// ST_START   | Start_o held for START_CYC cycles
// ST_RUN     | waiting for EndSw_i
// ST_DONE    | one cycle, raises status DONE + interrupt on exit
// ST_TIMEOUT | one cycle, raises status TIMEOUT + interrupt on exit
module cb_mode_sequencer
    import cb_mode_sequencer_pkg::*;
#(
    parameter int NHARTS      = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int START_CYC   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cb_mode_sequencer_if.slave bus
);

    localparam int              CNT_W          = $clog2(max_int(TIMEOUT_CYC, START_CYC) + 1);
    localparam logic [CNT_W-1:0] CNT_TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_START_LAST = CNT_W'(START_CYC - 1);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    cfg_shadow_t       r_shadow;
    cfg_shadow_t       r_applied;
    cfg_shadow_t       w_cfg_in;
    seq_status_e       r_status;
    seq_status_e       w_status_nxt;
    logic              r_irq;
    logic [NHARTS-1:0] r_dbg_req;
    logic [NHARTS-1:0] w_dbg_nxt;
    logic [NHARTS-1:0] w_quiesce_mask;
    logic [NHARTS-1:0] w_halt_req;
    logic              w_quiescent;
    logic              w_abort;
    logic              w_set;
    logic              w_capture;
    logic              w_apply;

`ifdef CB_SEQ_DEBUG_HALT_EN
    // Harts already halted in debug count as quiescent; awake, running harts get a halt request.
    assign w_quiesce_mask = bus.debug_mode_i;
    assign w_halt_req     = ~bus.sleep_i & ~bus.debug_mode_i;
`else
    logic w_unused_debug_mode;
    assign w_unused_debug_mode = ^bus.debug_mode_i;
    assign w_quiesce_mask      = '0;
    assign w_halt_req          = '0;
`endif

    assign w_quiescent = &(bus.sleep_i | w_quiesce_mask);
    assign w_abort     = bus.abort_i && (r_state != ST_IDLE);
    assign w_cfg_in    = {bus.cfg_safe_mode_i, bus.cfg_safe_config_i,
                          bus.cfg_master_core_i, bus.cfg_boot_addr_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_status_nxt = r_status;
        w_set        = 1'b0;
        w_capture    = 1'b0;
        w_apply      = 1'b0;
        w_dbg_nxt    = '0;

        if (w_abort) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_status_nxt = STAT_ABORT;
            w_set        = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start_req_i) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = '0;
                        w_capture   = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_quiescent) begin
                        w_state_nxt = ST_APPLY;
                        w_cnt_nxt   = '0;
                        w_apply     = 1'b1;
                    end else if (r_cnt == CNT_TMO_LAST) begin
                        w_state_nxt = ST_TIMEOUT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_dbg_nxt   = w_halt_req;
                    end
                end
                ST_APPLY: begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
                ST_START: begin
                    if (r_cnt == CNT_START_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.EndSw_i) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt  = ST_IDLE;
                    w_status_nxt = STAT_DONE;
                    w_set        = 1'b1;
                end
                ST_TIMEOUT: begin
                    w_state_nxt  = ST_IDLE;
                    w_status_nxt = STAT_TIMEOUT;
                    w_set        = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A new status event takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow  <= '0;
            r_applied <= '0;
            r_status  <= STAT_NONE;
            r_irq     <= 1'b0;
            r_dbg_req <= '0;
        end else begin
            if (w_capture) begin
                r_shadow <= w_cfg_in;
            end
            if (w_apply) begin
                r_applied <= r_shadow;
            end
            if (w_set) begin
                r_status <= w_status_nxt;
                r_irq    <= 1'b1;
            end else if (bus.irq_clr_i) begin
                r_status <= STAT_NONE;
                r_irq    <= 1'b0;
            end
            r_dbg_req <= w_dbg_nxt;
        end
    end

    assign bus.safe_mode_o          = r_applied.safe_mode;
    assign bus.safe_configuration_o = r_applied.safe_config;
    assign bus.master_core_o        = r_applied.master_core;
    assign bus.boot_addr_o          = r_applied.boot_addr;
    assign bus.Start_o              = (r_state == ST_START);
    assign bus.debug_req_o          = r_dbg_req;
    assign bus.busy_o               = (r_state != ST_IDLE);
    assign bus.status_o             = r_status;
    assign bus.interrupt_o          = r_irq;

endmodule
